// File: rtl/ysyx_22041752_axi_slave_mem_pkg.sv
// Shared AXI constants, FSM state encodings and address decode helper for the
// ysyx_22041752 AXI slave memory.
package ysyx_22041752_axi_slave_mem_pkg;

  localparam int AXI_DATA_WD = 64;
  localparam int AXI_STRB_WD = 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Offset is taken in 33 bits so a window ending at 2^32 still decodes.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/ysyx_22041752_axi_burst_addr.sv
// Next-beat address for an AXI burst; WRAP is deliberately treated as INCR.
module ysyx_22041752_axi_burst_addr
  import ysyx_22041752_axi_slave_mem_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_burst,
  output logic [31:0] o_next_addr
);

  logic [31:0] w_step;
  assign w_step = 32'd1 << i_size;

  always_comb begin
    o_next_addr = i_addr;
    case (i_burst)
      AXI_BURST_FIXED: o_next_addr = i_addr;
      AXI_BURST_INCR,
      AXI_BURST_WRAP:  o_next_addr = i_addr + w_step;
      default:         o_next_addr = i_addr + w_step;
    endcase
  end

endmodule

// File: rtl/ysyx_22041752_axi_slave_mem.sv
// AXI4 64-bit slave backed by an internal word memory; independent read/write FSMs.
// Define YSYX_22041752_AXI_SLAVE_DELAY_EN to add LFSR-driven response jitter.
module ysyx_22041752_axi_slave_mem
  import ysyx_22041752_axi_slave_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          ID_WD     = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_awvalid,
  output logic                   o_awready,
  input  logic [ID_WD-1:0]       i_awid,
  input  logic [31:0]            i_awaddr,
  input  logic [7:0]             i_awlen,
  input  logic [2:0]             i_awsize,
  input  logic [1:0]             i_awburst,
  input  logic                   i_wvalid,
  output logic                   o_wready,
  input  logic [AXI_DATA_WD-1:0] i_wdata,
  input  logic [AXI_STRB_WD-1:0] i_wstrb,
  input  logic                   i_wlast,
  output logic                   o_bvalid,
  input  logic                   i_bready,
  output logic [ID_WD-1:0]       o_bid,
  output logic [1:0]             o_bresp,
  input  logic                   i_arvalid,
  output logic                   o_arready,
  input  logic [ID_WD-1:0]       i_arid,
  input  logic [31:0]            i_araddr,
  input  logic [7:0]             i_arlen,
  input  logic [2:0]             i_arsize,
  input  logic [1:0]             i_arburst,
  output logic                   o_rvalid,
  input  logic                   i_rready,
  output logic [ID_WD-1:0]       o_rid,
  output logic [AXI_DATA_WD-1:0] o_rdata,
  output logic [1:0]             o_rresp,
  output logic                   o_rlast,
  output w_state_e               o_w_state,
  output r_state_e               o_r_state
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 3;

  logic [AXI_DATA_WD-1:0] r_mem [DEPTH];

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  w_state_e r_w_state, w_w_state_n;
  logic r_awready, w_awready_n, r_wready, w_wready_n, r_bvalid, w_bvalid_n;
  logic [ID_WD-1:0] r_bid, w_bid_n, r_w_id, w_w_id_n;
  logic [1:0] r_bresp, w_bresp_n, r_w_burst, w_w_burst_n;
  logic [31:0] r_w_addr, w_w_addr_n, w_w_next;
  logic [7:0] r_w_len, w_w_len_n, r_w_cnt, w_w_cnt_n;
  logic [2:0] r_w_size, w_w_size_n;
  logic r_w_dec, w_w_dec_n, r_w_slv, w_w_slv_n;
  logic w_wready, w_w_inr, w_w_last, w_mem_we;

  r_state_e r_r_state, w_r_state_n;
  logic r_arready, w_arready_n, r_rvalid, w_rvalid_n, r_rlast, w_rlast_n;
  logic [ID_WD-1:0] r_rid, w_rid_n, r_r_id, w_r_id_n;
  logic [AXI_DATA_WD-1:0] r_rdata, w_rdata_n, w_r_word;
  logic [1:0] r_rresp, w_rresp_n, r_r_burst, w_r_burst_n;
  logic [31:0] r_r_addr, w_r_addr_n, w_r_next, w_r_load_addr;
  logic [7:0] r_r_len, w_r_len_n, r_r_cnt, w_r_cnt_n;
  logic [2:0] r_r_size, w_r_size_n;
  logic w_r_inr;

`ifdef YSYX_22041752_AXI_SLAVE_DELAY_EN
  logic [7:0] r_lfsr;
  logic [2:0] r_w_dly, w_w_dly_n, r_r_dly, w_r_dly_n;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_lfsr <= 8'hA5;
    else         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_wready = r_wready & r_lfsr[0];
`else
  assign w_wready = r_wready;
`endif

  ysyx_22041752_axi_burst_addr u_w_addr (
    .i_addr(r_w_addr), .i_size(r_w_size), .i_burst(r_w_burst), .o_next_addr(w_w_next)
  );
  ysyx_22041752_axi_burst_addr u_r_addr (
    .i_addr(r_r_addr), .i_size(r_r_size), .i_burst(r_r_burst), .o_next_addr(w_r_next)
  );

  assign w_w_inr  = addr_in_range(r_w_addr, BASE_ADDR, SPAN);
  assign w_w_last = (r_w_cnt == r_w_len);

  always_comb begin
    w_w_state_n = r_w_state;
    w_awready_n = r_awready;
    w_wready_n  = r_wready;
    w_bvalid_n  = r_bvalid;
    w_bid_n     = r_bid;
    w_bresp_n   = r_bresp;
    w_w_id_n    = r_w_id;
    w_w_addr_n  = r_w_addr;
    w_w_len_n   = r_w_len;
    w_w_size_n  = r_w_size;
    w_w_burst_n = r_w_burst;
    w_w_cnt_n   = r_w_cnt;
    w_w_dec_n   = r_w_dec;
    w_w_slv_n   = r_w_slv;
    w_mem_we    = 1'b0;
`ifdef YSYX_22041752_AXI_SLAVE_DELAY_EN
    w_w_dly_n   = r_w_dly;
`endif
    case (r_w_state)
      W_IDLE: if (i_awvalid && r_awready) begin
        w_w_id_n    = i_awid;
        w_w_addr_n  = i_awaddr;
        w_w_len_n   = i_awlen;
        w_w_size_n  = i_awsize;
        w_w_burst_n = i_awburst;
        w_w_cnt_n   = 8'd0;
        w_w_dec_n   = 1'b0;
        w_w_slv_n   = 1'b0;
        w_awready_n = 1'b0;
        w_wready_n  = 1'b1;
        w_w_state_n = W_DATA;
      end
      W_DATA: if (i_wvalid && w_wready) begin
        w_mem_we   = w_w_inr;
        w_w_dec_n  = r_w_dec | ~w_w_inr;
        w_w_slv_n  = r_w_slv | (i_wlast ^ w_w_last);
        w_w_addr_n = w_w_next;
        w_w_cnt_n  = r_w_cnt + 8'd1;
        if (w_w_last) begin
          w_wready_n  = 1'b0;
          w_bvalid_n  = 1'b1;
          w_bid_n     = r_w_id;
          w_bresp_n   = w_w_dec_n ? AXI_RESP_DECERR :
                        (w_w_slv_n ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
          w_w_state_n = W_RESP;
`ifdef YSYX_22041752_AXI_SLAVE_DELAY_EN
          w_bvalid_n  = (r_lfsr[2:0] == 3'd0);
          w_w_dly_n   = r_lfsr[2:0];
`endif
        end
      end
      W_RESP: begin
        if (r_bvalid && i_bready) begin
          w_bvalid_n  = 1'b0;
          w_awready_n = 1'b1;
          w_w_state_n = W_IDLE;
        end
`ifdef YSYX_22041752_AXI_SLAVE_DELAY_EN
        if (!r_bvalid) begin
          w_w_dly_n  = r_w_dly - 3'd1;
          w_bvalid_n = (r_w_dly <= 3'd1);
        end
`endif
      end
      default: w_w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_w_state <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
      r_w_id    <= '0;
      r_w_addr  <= '0;
      r_w_len   <= '0;
      r_w_size  <= '0;
      r_w_burst <= '0;
      r_w_cnt   <= '0;
      r_w_dec   <= 1'b0;
      r_w_slv   <= 1'b0;
    end else begin
      r_w_state <= w_w_state_n;
      r_awready <= w_awready_n;
      r_wready  <= w_wready_n;
      r_bvalid  <= w_bvalid_n;
      r_bid     <= w_bid_n;
      r_bresp   <= w_bresp_n;
      r_w_id    <= w_w_id_n;
      r_w_addr  <= w_w_addr_n;
      r_w_len   <= w_w_len_n;
      r_w_size  <= w_w_size_n;
      r_w_burst <= w_w_burst_n;
      r_w_cnt   <= w_w_cnt_n;
      r_w_dec   <= w_w_dec_n;
      r_w_slv   <= w_w_slv_n;
    end
  end

  // Memory has no reset; a reset edge suppresses any in-flight beat write.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_mem_we) begin
      for (int b = 0; b < AXI_STRB_WD; b++) begin
        if (i_wstrb[b]) r_mem[word_idx(r_w_addr)][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // r_r_addr tracks the beat on the bus; the next beat is fetched on its handshake.
  assign w_r_load_addr = r_rvalid ? w_r_next : r_r_addr;
  assign w_r_inr       = addr_in_range(w_r_load_addr, BASE_ADDR, SPAN);
  assign w_r_word      = r_mem[word_idx(w_r_load_addr)];

  always_comb begin
    w_r_state_n = r_r_state;
    w_arready_n = r_arready;
    w_rvalid_n  = r_rvalid;
    w_rlast_n   = r_rlast;
    w_rid_n     = r_rid;
    w_rdata_n   = r_rdata;
    w_rresp_n   = r_rresp;
    w_r_id_n    = r_r_id;
    w_r_addr_n  = r_r_addr;
    w_r_len_n   = r_r_len;
    w_r_size_n  = r_r_size;
    w_r_burst_n = r_r_burst;
    w_r_cnt_n   = r_r_cnt;
`ifdef YSYX_22041752_AXI_SLAVE_DELAY_EN
    w_r_dly_n   = r_r_dly;
`endif
    case (r_r_state)
      R_IDLE: if (i_arvalid && r_arready) begin
        w_r_id_n    = i_arid;
        w_r_addr_n  = i_araddr;
        w_r_len_n   = i_arlen;
        w_r_size_n  = i_arsize;
        w_r_burst_n = i_arburst;
        w_r_cnt_n   = 8'd0;
        w_arready_n = 1'b0;
        w_r_state_n = R_DATA;
`ifdef YSYX_22041752_AXI_SLAVE_DELAY_EN
        w_r_dly_n   = r_lfsr[2:0];
`endif
      end
      R_DATA: begin
        if (!r_rvalid) begin
`ifdef YSYX_22041752_AXI_SLAVE_DELAY_EN
          if (r_r_dly != 3'd0) w_r_dly_n = r_r_dly - 3'd1;
          else begin
`endif
          w_rvalid_n = 1'b1;
          w_rid_n    = r_r_id;
          w_rdata_n  = w_r_inr ? w_r_word : '0;
          w_rresp_n  = w_r_inr ? AXI_RESP_OKAY : AXI_RESP_DECERR;
          w_rlast_n  = (r_r_len == 8'd0);
`ifdef YSYX_22041752_AXI_SLAVE_DELAY_EN
          end
`endif
        end else if (i_rready) begin
          if (r_rlast) begin
            w_rvalid_n  = 1'b0;
            w_rlast_n   = 1'b0;
            w_arready_n = 1'b1;
            w_r_state_n = R_IDLE;
          end else begin
            w_r_addr_n = w_r_next;
            w_r_cnt_n  = r_r_cnt + 8'd1;
            w_rdata_n  = w_r_inr ? w_r_word : '0;
            w_rresp_n  = w_r_inr ? AXI_RESP_OKAY : AXI_RESP_DECERR;
            w_rlast_n  = ((r_r_cnt + 8'd1) == r_r_len);
          end
        end
      end
      default: w_r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_r_state <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_r_id    <= '0;
      r_r_addr  <= '0;
      r_r_len   <= '0;
      r_r_size  <= '0;
      r_r_burst <= '0;
      r_r_cnt   <= '0;
`ifdef YSYX_22041752_AXI_SLAVE_DELAY_EN
      r_w_dly   <= '0;
      r_r_dly   <= '0;
`endif
    end else begin
      r_r_state <= w_r_state_n;
      r_arready <= w_arready_n;
      r_rvalid  <= w_rvalid_n;
      r_rlast   <= w_rlast_n;
      r_rid     <= w_rid_n;
      r_rdata   <= w_rdata_n;
      r_rresp   <= w_rresp_n;
      r_r_id    <= w_r_id_n;
      r_r_addr  <= w_r_addr_n;
      r_r_len   <= w_r_len_n;
      r_r_size  <= w_r_size_n;
      r_r_burst <= w_r_burst_n;
      r_r_cnt   <= w_r_cnt_n;
`ifdef YSYX_22041752_AXI_SLAVE_DELAY_EN
      r_w_dly   <= w_w_dly_n;
      r_r_dly   <= w_r_dly_n;
`endif
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = w_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bid     = r_bid;
  assign o_bresp   = r_bresp;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rid     = r_rid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;
  assign o_rlast   = r_rlast;
  assign o_w_state = r_w_state;
  assign o_r_state = r_r_state;

endmodule

// File: tb/tb_ysyx_22041752_axi_slave_mem.sv
// Scoreboard bench for ysyx_22041752_axi_slave_mem: drivers push expected B/R
// responses from a byte-level memory model; a negedge monitor pops and compares.
module tb_ysyx_22041752_axi_slave_mem;
  import ysyx_22041752_axi_slave_mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          ID_WD = 4;
  localparam logic [31:0] TOP   = BASE + 32'(DEPTH * 8);

  logic i_clk, i_reset;
  logic i_awvalid, o_awready, i_wvalid, o_wready, i_wlast, o_bvalid, i_bready;
  logic i_arvalid, o_arready, o_rvalid, i_rready, o_rlast;
  logic [ID_WD-1:0] i_awid, o_bid, i_arid, o_rid;
  logic [31:0] i_awaddr, i_araddr;
  logic [7:0] i_awlen, i_arlen, i_wstrb;
  logic [2:0] i_awsize, i_arsize;
  logic [1:0] i_awburst, i_arburst, o_bresp, o_rresp;
  logic [63:0] i_wdata, o_rdata;
  w_state_e o_w_state;
  r_state_e o_r_state;

  ysyx_22041752_axi_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .ID_WD(ID_WD)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid), .i_awaddr(i_awaddr),
    .i_awlen(i_awlen), .i_awsize(i_awsize), .i_awburst(i_awburst),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .i_wlast(i_wlast), .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid),
    .o_bresp(o_bresp), .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arid(i_arid),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rdata(o_rdata),
    .o_rresp(o_rresp), .o_rlast(o_rlast), .o_w_state(o_w_state), .o_r_state(o_r_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] mem_m [int];
  logic [5:0]  exp_b_q [$];   // {id, resp}
  logic [70:0] exp_r_q [$];   // {id, data, resp, last}
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b00) return a;
    return a + 32'(i) * (32'd1 << size);
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < TOP);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  function automatic logic pick(input int sel);
    case (sel)
      0: return o_awready;
      1: return o_wready;
      2: return o_bvalid;
      3: return o_arready;
      default: return o_rvalid;
    endcase
  endfunction

  task automatic wait_hi(input int sel, input string name);
    int to;
    logic v;
    to = 0;
    do begin
      @(negedge i_clk);
      to++;
      v = pick(sel);
    end while (!v && to < 64);
    chk(name, 71'(v), 71'(1));
  endtask

  task automatic fill(input int n, input bit rand_strb);
    for (int i = 0; i < n; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = rand_strb ? 8'($urandom) : 8'hFF;
    end
  endtask

  // ---------------- monitor ----------------
  logic        stall_prev = 1'b0;
  logic [70:0] stall_val;
  always @(negedge i_clk) begin
    if (i_reset) stall_prev = 1'b0;
    else begin
      if (o_bvalid && i_bready) begin
        if (exp_b_q.size() == 0) chk("b_unexpected", 71'(exp_b_q.size()), 71'(1));
        else chk("b_resp", {o_bid, o_bresp}, 71'(exp_b_q.pop_front()));
      end
      if (stall_prev && o_rvalid) chk("r_stable", {o_rid, o_rdata, o_rresp, o_rlast}, stall_val);
      if (o_rvalid && i_rready) begin
        if (exp_r_q.size() == 0) chk("r_unexpected", 71'(exp_r_q.size()), 71'(1));
        else chk("r_beat", {o_rid, o_rdata, o_rresp, o_rlast}, exp_r_q.pop_front());
      end
      stall_prev = o_rvalid && !i_rready;
      stall_val  = {o_rid, o_rdata, o_rresp, o_rlast};
    end
  end

  // ---------------- drivers ----------------
  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id, input int wlast_at);
    logic dec, slv;
    logic [31:0] a;
    logic [63:0] w;
    int wl, d;
    wl  = (wlast_at < 0) ? int'(len) : wlast_at;
    dec = 1'b0;
    slv = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (!in_rng(beat_addr(addr, i, size, burst))) dec = 1'b1;
      if ((i == wl) != (i == int'(len))) slv = 1'b1;
    end
    exp_b_q.push_back({id, dec ? 2'b11 : (slv ? 2'b10 : 2'b00)});
    i_awvalid = 1'b1; i_awid = id; i_awaddr = addr; i_awlen = len;
    i_awsize = size; i_awburst = burst;
    wait_hi(0, "aw_ready");
    @(posedge i_clk); #1;
    i_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      i_wvalid = 1'b1; i_wdata = wd[i]; i_wstrb = ws[i]; i_wlast = (i == wl);
      wait_hi(1, "w_ready");
      a = beat_addr(addr, i, size, burst);
      if (in_rng(a)) begin
        w = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 64'h0;
        for (int b = 0; b < 8; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
        mem_m[widx(a)] = w;
      end
      @(posedge i_clk); #1;
    end
    i_wvalid = 1'b0; i_wlast = 1'b0;
    d = $urandom_range(0, 2);
    repeat (d) begin @(posedge i_clk); #1; end
    i_bready = 1'b1;
    wait_hi(2, "b_valid");
    @(posedge i_clk); #1;
    i_bready = 1'b0;
  endtask

  task automatic push_read_exp(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [3:0] id);
    logic [31:0] a;
    logic [63:0] d;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, i, size, burst);
      d = (in_rng(a) && mem_m.exists(widx(a))) ? mem_m[widx(a)] : 64'h0;
      exp_r_q.push_back({id, d, in_rng(a) ? 2'b00 : 2'b11, 1'(i == int'(len))});
    end
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id,
                            input int stall_at, input int stall_n);
    push_read_exp(addr, len, size, burst, id);
    i_arvalid = 1'b1; i_arid = id; i_araddr = addr; i_arlen = len;
    i_arsize = size; i_arburst = burst;
    wait_hi(3, "ar_ready");
    @(posedge i_clk); #1;
    i_arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_at) begin
        i_rready = 1'b0;
        repeat (stall_n) begin @(posedge i_clk); #1; end
      end
      i_rready = 1'b1;
      wait_hi(4, "r_valid");
      @(posedge i_clk); #1;
    end
    i_rready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ad;
    logic [7:0]  ln;
    logic [1:0]  bu;
    logic [2:0]  sz;
    logic        top_case;
    int          to;
    i_reset = 1'b1;
    i_awvalid = 1'b0; i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0;
    i_wvalid = 1'b0; i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_bready = 1'b0;
    i_arvalid = 1'b0; i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0;
    i_rready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_awready", 71'(o_awready), 71'(1));
    chk("rst_arready", 71'(o_arready), 71'(1));
    chk("rst_wready",  71'(o_wready),  71'(0));
    chk("rst_bvalid",  71'(o_bvalid),  71'(0));
    chk("rst_rvalid",  71'(o_rvalid),  71'(0));
    chk("rst_rlast",   71'(o_rlast),   71'(0));
    chk("rst_ids",     71'({o_bid, o_rid}), 71'(0));
    chk("rst_resps",   71'({o_bresp, o_rresp}), 71'(0));
    chk("rst_rdata",   71'(o_rdata),   71'(0));
    chk("rst_w_state", 71'(o_w_state), 71'(W_IDLE));
    chk("rst_r_state", 71'(o_r_state), 71'(R_IDLE));
    i_reset = 1'b0;

    // 256-beat INCR write/read also seeds the low region for later tests.
    fill(256, 1'b0);
    write_burst(BASE, 8'd255, 3'd3, 2'b01, 4'h1, -1);
    read_burst(BASE, 8'd255, 3'd3, 2'b01, 4'h2, -1, 0);

    wd[0] = 64'h1122_3344_5566_7788; ws[0] = 8'hFF;
    write_burst(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'h3, -1);
    read_burst(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'h4, -1, 0);
    wd[0] = 64'hFFFF_FFFF_AAAA_AAAA; ws[0] = 8'h0F;
    write_burst(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'h5, -1);
    chk("model_partial", 71'(mem_m[2]), 71'(64'h1122_3344_AAAA_AAAA));
    read_burst(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'h6, -1, 0);

    read_burst(BASE, 8'd3, 3'd3, 2'b01, 4'h7, 2, 2);
    read_burst(32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 4'h8, -1, 0);
    fill(2, 1'b0);
    write_burst(TOP - 32'd8, 8'd1, 3'd3, 2'b01, 4'h9, -1);
    read_burst(TOP - 32'd8, 8'd1, 3'd3, 2'b01, 4'hA, -1, 0);
    fill(3, 1'b1);
    write_burst(BASE + 32'h40, 8'd2, 3'd3, 2'b01, 4'hB, 1);
    read_burst(BASE + 32'h40, 8'd2, 3'd3, 2'b01, 4'hC, -1, 0);
    fill(4, 1'b1);
    write_burst(BASE + 32'h80, 8'd3, 3'd3, 2'b00, 4'hD, -1);
    read_burst(BASE + 32'h80, 8'd3, 3'd3, 2'b00, 4'hE, 1, 1);

    // Same-word write and read accepted together: read sees the old word.
    wd[0] = 64'hDEAD_BEEF_CAFE_F00D; ws[0] = 8'hFF;
    fork
      write_burst(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'h1, -1);
      read_burst(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'h2, -1, 0);
      begin
        @(negedge i_clk);
        chk("aw_ar_same_cycle", 71'({i_awvalid, i_arvalid, o_awready, o_arready}), 71'(4'hF));
      end
    join
    read_burst(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'h3, -1, 0);

    for (int t = 0; t < 24; t++) begin
      top_case = ($urandom_range(0, 5) == 0);
      if (top_case) begin
        ad = TOP - 32'(8 * $urandom_range(1, 3)); ln = 8'($urandom_range(0, 5));
        bu = 2'b01; sz = 3'd3;
      end else begin
        ad = BASE + 32'(8 * $urandom_range(0, 240)); ln = 8'($urandom_range(0, 7));
        bu = 2'($urandom_range(0, 2)); sz = ($urandom_range(0, 3) == 0) ? 3'd2 : 3'd3;
      end
      fill(int'(ln) + 1, !top_case);
      write_burst(ad, ln, sz, bu, 4'($urandom), ($urandom_range(0, 4) == 0) ? 0 : -1);
      read_burst(ad, ln, sz, bu, 4'($urandom), int'($urandom_range(0, 8)), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of an 8-beat read.
    push_read_exp(BASE, 8'd7, 3'd3, 2'b01, 4'h6);
    i_arvalid = 1'b1; i_arid = 4'h6; i_araddr = BASE; i_arlen = 8'd7;
    i_arsize = 3'd3; i_arburst = 2'b01;
    wait_hi(3, "ar_ready_rst");
    @(posedge i_clk); #1;
    i_arvalid = 1'b0;
    i_rready  = 1'b1;
    repeat (3) begin @(posedge i_clk); #1; end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    chk("midrst_rvalid",  71'(o_rvalid),  71'(0));
    chk("midrst_arready", 71'(o_arready), 71'(1));
    chk("midrst_r_state", 71'(o_r_state), 71'(R_IDLE));
    i_rready = 1'b0;
    exp_r_q.delete();
    read_burst(BASE + 32'h20, 8'd1, 3'd3, 2'b01, 4'h7, -1, 0);

    to = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && to < 20) begin
      @(posedge i_clk);
      to++;
    end
    chk("exp_b_q_drained", 71'(exp_b_q.size()), 71'(0));
    chk("exp_r_q_drained", 71'(exp_r_q.size()), 71'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041752_axi_slave_mem.md
Name: ysyx_22041752_axi_slave_mem

Overview:
- AXI4 responder, 64-bit data: the far end of the core's AXI master port.
- Backs the core in NPC simulation with an internal word memory, replacing the external memory model.
- Read and write channels are independent FSMs, each handling one outstanding transaction.
- Supports single and burst (FIXED/INCR) transfers.

Parameters:
- BASE_ADDR, 32'h8000_0000, first byte address decoded by this slave
- DEPTH, 4096, number of 64-bit words (power of 2)
- ID_WD, 4, AXI ID width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- awvalid/awready  in/out  1  write address handshake
- awid  in  ID_WD  write transaction ID
- awaddr  in  32  write start byte address
- awlen  in  8  write beats minus 1
- awsize  in  3  write beat size
- awburst  in  2  write burst type
- wvalid/wready  in/out  1  write data handshake
- wdata  in  64  write data
- wstrb  in  8  byte enables
- wlast  in  1  last write beat
- bvalid/bready  out/in  1  write response handshake
- bid  out  ID_WD  echoed awid
- bresp  out  2  write response
- arvalid/arready  in/out  1  read address handshake
- arid  in  ID_WD  read transaction ID
- araddr  in  32  read start byte address
- arlen  in  8  read beats minus 1
- arsize  in  3  read beat size
- arburst  in  2  read burst type
- rvalid/rready  out/in  1  read data handshake
- rid  out  ID_WD  echoed arid
- rdata  out  64  read data
- rresp  out  2  read response
- rlast  out  1  last read beat

Behaviour:
- Reset values (next edge with reset=1): awready=1, arready=1; wready=0, bvalid=0, rvalid=0, rlast=0; bid/rid/bresp/rresp/rdata=0.
- Reset mid-burst abandons the burst; no memory write occurs on the reset cycle.
- Memory contents are not reset.

Write FSM, states W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
- W_IDLE: awready=1. On awvalid&awready, latch id, addr, len, size, burst; zero the beat counter; awready<=0, wready<=1.
- W_DATA: each wvalid&wready writes the bytes selected by wstrb into word (addr-BASE_ADDR)>>3, but only if the address is in range.
- After each beat, INCR adds (1<<size) to addr; FIXED holds addr; WRAP (2'b10) is treated as INCR.
- Write leaves W_DATA on the beat where counter==len. That cycle sets wready<=0 and bvalid<=1.
- W_RESP: bid=latched id; hold bvalid until bready; then awready<=1 and return to W_IDLE.
- bresp priority: 2'b11 DECERR if any beat address was out of range; else 2'b10 SLVERR if wlast disagrees with counter==len on any beat; else 2'b00.

Read FSM, states R_IDLE -> R_DATA -> R_IDLE:
- R_IDLE: arready=1. On arvalid&arready, latch the request; arready<=0.
- R_DATA: the next cycle presents beat 0 with rvalid=1, rdata=mem[word], rresp=00, rlast=(len==0).
- Each rvalid&rready advances addr (same rule as writes) and loads the next beat registered on the same edge, so rvalid stays high: 1 beat/cycle.
- Out-of-range beat: rdata=0, rresp=2'b11.
- rvalid, rdata, rresp and rlast hold stable while rready=0.
- After the rlast handshake: rvalid<=0, arready<=1, return to R_IDLE.

Boundaries:
- Address to word index: (addr-BASE_ADDR)>>3; the low 3 bits are ignored for indexing.
- Beat address is in range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH*8.
- An INCR burst crossing the top of memory gets DECERR for the overflowing beats only.
- awlen=255 gives 256 beats; the 8-bit counter must not wrap early.
- A simultaneous write and read of the same word in the same cycle returns the old data; the write is visible on the next beat or transaction.
- arvalid and awvalid asserted in the same cycle are both accepted.

Optional Feature:
- Macro: YSYX_22041752_AXI_SLAVE_DELAY_EN.
- Defined: an 8-bit LFSR (seed 8'hA5 at reset) inserts delay.
  - After AR acceptance, beat 0 waits lfsr[2:0] cycles; bvalid also waits lfsr[2:0] cycles after the last W beat.
  - In W_DATA, wready is deasserted on cycles where lfsr[0]=0.
  - The LFSR steps every cycle.
- Undefined: fixed timing as above (beat 0 one cycle after AR, wready constantly 1 in W_DATA, bvalid the cycle after the last W beat).

Decomposition:
- Shared package/header entries: AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, AXI_BURST_FIXED/INCR/WRAP, W and R state encodings, AXI_DATA_WD=64, AXI_STRB_WD=8.
- Sub-module ysyx_22041752_axi_burst_addr: combinational next-beat address from addr, size and burst; one instance per channel.

Test Plan:
- Single write then read: AW addr 8000_0010, len 0, wdata 1122334455667788, wstrb FF -> bresp 00. Then AR same addr -> rdata 1122334455667788, rresp 00, rlast 1.
- Partial strobe: write 0F / data FFFFFFFF_AAAAAAAA over the prior word -> readback 11223344_AAAAAAAA.
- INCR read burst: len 3 from 8000_0000 with rready held low 2 cycles mid-burst -> 4 beats of consecutive words, data stable while stalled, rlast only on beat 3.
- Out of range: AR addr 7FFF_FFF8 -> rresp 11, rdata 0. INCR write len 1 at BASE+DEPTH*8-8 -> first word written, bresp 11.
- wlast early: len 2 with wlast on beat 1 -> all 3 beats accepted, bresp 10.
- Concurrent and reset: simultaneous AW and AR both accepted in the same cycle. Reset asserted mid read burst -> next cycle rvalid 0, arready 1, and the next AR completes normally.
